// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param
// Purpose  : Parametrised CPU register file. DEPTH entries of WIDTH bits,
//            one synchronous write port and two combinational read ports.
//            Optional write-to-read bypass, optional hardwired-zero entry 0,
//            and a sequential soft-clear engine that zeroes one entry per
//            cycle. Writes are suppressed while the data memory is BUSY.
// Ports    : CLK          - clock, rising-edge active
//            RESET_N      - synchronous active-low reset
//            IN           - write data (WIDTH)
//            INADDRESS    - write address (ADDR_W)
//            WRITE        - write enable
//            BUSY         - data-memory stall, drops writes
//            CLEAR        - request a sequential clear of all entries
//            OUT1ADDRESS  - read port 1 address (ADDR_W)
//            OUT2ADDRESS  - read port 2 address (ADDR_W)
//            OUT1, OUT2   - combinational read data (WIDTH)
//            READY        - 1 = idle and accepting writes, 0 = clearing
// Revision : 1.0 - initial release
// ============================================================================
module regfile_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [WIDTH-1:0]  IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic              BUSY,
    input  logic              CLEAR,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [WIDTH-1:0]  OUT1,
    output logic [WIDTH-1:0]  OUT2,
    output logic              READY
);

    localparam logic [0:0]        c_ST_IDLE     = 1'b0;
    localparam logic [0:0]        c_ST_CLEARING = 1'b1;
    // One extra bit so that DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   c_DEPTH_EXT   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST        = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;

    logic w_ready;
    logic w_wr_en;
    logic w_wr_ok;

    function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < c_DEPTH_EXT);
    endfunction

    function automatic logic f_is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign w_ready = (r_state == c_ST_IDLE);
    // CLEAR wins over a same-cycle write; the write is simply lost.
    assign w_wr_en = WRITE & ~BUSY & w_ready & ~CLEAR;
    // A write that will actually land in the array; only these may bypass.
    assign w_wr_ok = w_wr_en & f_in_range(INADDRESS) & ~f_is_zero_reg(INADDRESS);

    // Read mux shared by both ports: bypass first, then range/zero masking.
    function automatic logic [WIDTH-1:0] f_read(
        input logic [ADDR_W-1:0] a,
        input logic              wr_ok,
        input logic [ADDR_W-1:0] wa,
        input logic [WIDTH-1:0]  wd
    );
        logic [WIDTH-1:0] v;
        v = '0;
        if ((BYPASS != 0) && wr_ok && (a == wa)) begin
            v = wd;
        end else if (f_in_range(a) && !f_is_zero_reg(a)) begin
            v = r_mem[a];
        end
        return v;
    endfunction

    always_comb begin
        OUT1 = f_read(OUT1ADDRESS, w_wr_ok, INADDRESS, IN);
        OUT2 = f_read(OUT2ADDRESS, w_wr_ok, INADDRESS, IN);
    end

    assign READY = w_ready;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (CLEAR) begin
                        r_state <= c_ST_CLEARING;
                        r_ptr   <= '0;
                    end else if (w_wr_ok) begin
                        r_mem[INADDRESS] <= IN;
                    end
                end
                c_ST_CLEARING: begin
                    // One entry per edge; leave after the last entry is zeroed,
                    // giving exactly DEPTH cycles with READY low.
                    r_mem[r_ptr] <= '0;
                    if (r_ptr == c_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_param
// Purpose  : Self-checking bench for regfile_param. Three instances share one
//            stimulus stream: u0 (bypass, no zero reg), u1 (no bypass),
//            u2 (bypass + hardwired zero reg). Every instance is compared
//            each cycle against a per-instance behavioural model, plus a
//            directed vector table and hand-written clear/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_param;

    localparam int c_N     = 3;
    localparam int c_DEPTH = 8;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITE;
    logic       BUSY;
    logic       CLEAR;
    logic [2:0] A1;
    logic [2:0] A2;
    logic [7:0] out1 [c_N];
    logic [7:0] out2 [c_N];
    logic       rdy  [c_N];

    int checks   = 0;
    int failures = 0;

    // Behavioural model: contents plus number of clear cycles still to run.
    logic [7:0] mem  [c_N][c_DEPTH];
    int         left [c_N];

    regfile_param #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) u0 (
        .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .BUSY(BUSY), .CLEAR(CLEAR), .OUT1ADDRESS(A1), .OUT2ADDRESS(A2),
        .OUT1(out1[0]), .OUT2(out2[0]), .READY(rdy[0]));
    regfile_param #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) u1 (
        .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .BUSY(BUSY), .CLEAR(CLEAR), .OUT1ADDRESS(A1), .OUT2ADDRESS(A2),
        .OUT1(out1[1]), .OUT2(out2[1]), .READY(rdy[1]));
    regfile_param #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) u2 (
        .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .BUSY(BUSY), .CLEAR(CLEAR), .OUT1ADDRESS(A1), .OUT2ADDRESS(A2),
        .OUT1(out1[2]), .OUT2(out2[2]), .READY(rdy[2]));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic bit has_bypass(int i);
        return i != 1;
    endfunction

    function automatic bit has_zero(int i);
        return i == 2;
    endfunction

    function automatic logic [7:0] exp_read(int i, logic [2:0] a);
        bit accepted;
        accepted = WRITE && !BUSY && !CLEAR && (left[i] == 0) &&
                   !(has_zero(i) && INADDRESS == 3'd0);
        if (has_bypass(i) && accepted && a == INADDRESS) return IN;
        if (has_zero(i) && a == 3'd0) return 8'h00;
        return mem[i][a];
    endfunction

    task automatic model_edge();
        for (int i = 0; i < c_N; i++) begin
            if (!RESET_N) begin
                for (int k = 0; k < c_DEPTH; k++) mem[i][k] = 8'h00;
                left[i] = 0;
            end else if (left[i] > 0) begin
                mem[i][c_DEPTH - left[i]] = 8'h00;
                left[i] = left[i] - 1;
            end else if (CLEAR) begin
                left[i] = c_DEPTH;
            end else if (WRITE && !BUSY && !(has_zero(i) && INADDRESS == 3'd0)) begin
                mem[i][INADDRESS] = IN;
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic rn, input logic wr, input logic bz, input logic cl,
                         input logic [7:0] d, input logic [2:0] wa,
                         input logic [2:0] a1, input logic [2:0] a2);
        RESET_N = rn; WRITE = wr; BUSY = bz; CLEAR = cl;
        IN = d; INADDRESS = wa; A1 = a1; A2 = a2;
    endtask

    // Called shortly after a falling edge with inputs already driven.
    task automatic step();
        #1;
        for (int i = 0; i < c_N; i++) begin
            chk($sformatf("u%0d_out1_a%0d", i, A1), out1[i], exp_read(i, A1));
            chk($sformatf("u%0d_out2_a%0d", i, A2), out2[i], exp_read(i, A2));
            chk($sformatf("u%0d_ready", i), {7'd0, rdy[i]}, {7'd0, left[i] == 0});
        end
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle(input logic [2:0] a1, input logic [2:0] a2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, a1, a2);
    endtask

    typedef struct {
        logic       wr;
        logic       busy;
        logic [7:0] din;
        logic [2:0] wa;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       erdy;
    } vec_t;

    vec_t vecs [9];
    int   n;

    initial begin
        // Expected values below are for u0 (bypass on, zero reg off), before the edge.
        vecs[0] = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd3, 3'd7, 8'h00, 8'h00, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 8'hA5, 3'd3, 3'd3, 3'd7, 8'hA5, 8'h00, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 8'h3C, 3'd7, 3'd3, 3'd7, 8'hA5, 8'h3C, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd3, 3'd7, 8'hA5, 8'h3C, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 8'h77, 3'd3, 3'd3, 3'd3, 8'hA5, 8'hA5, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd3, 3'd3, 8'hA5, 8'hA5, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 8'h5A, 3'd2, 3'd2, 3'd2, 8'h5A, 8'h5A, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 8'h66, 3'd0, 3'd0, 3'd0, 8'h66, 8'h66, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd2, 8'h66, 8'h5A, 1'b1};

        // Reset held for two edges; outputs are unknown until then.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0);
        for (int k = 0; k < 2; k++) begin
            model_edge();
            @(posedge CLK);
        end
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            idle(3'(2*k), 3'(2*k+1));
            #1;
            chk("reset_out1", out1[0], 8'h00);
            chk("reset_out2", out2[0], 8'h00);
            step();
        end

        // Directed vector table.
        for (int v = 0; v < 9; v++) begin
            drive(1'b1, vecs[v].wr, vecs[v].busy, 1'b0, vecs[v].din, vecs[v].wa, vecs[v].a1, vecs[v].a2);
            #1;
            chk($sformatf("vec%0d_out1", v), out1[0], vecs[v].e1);
            chk($sformatf("vec%0d_out2", v), out2[0], vecs[v].e2);
            chk($sformatf("vec%0d_ready", v), {7'd0, rdy[0]}, {7'd0, vecs[v].erdy});
            step();
        end

        // No bypass: old value before the edge, new value after.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 3'd2, 3'd2, 3'd2);
        #1;
        chk("nobyp_before", out1[1], 8'h5A);
        chk("byp_before", out2[0], 8'hC3);
        step();
        idle(3'd2, 3'd2);
        #1;
        chk("nobyp_after", out1[1], 8'hC3);
        step();

        // Hardwired zero register.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 3'd0, 3'd0, 3'd0);
        #1;
        chk("zreg_bypass", out1[2], 8'h00);
        step();
        idle(3'd0, 3'd0);
        #1;
        chk("zreg_read", out1[2], 8'h00);
        chk("nozreg_read", out1[0], 8'hFF);
        step();

        // Sequential clear.
        for (int k = 0; k < c_DEPTH; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h11 * (k + 1)), 3'(k), 3'(k), 3'(k));
            step();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'hEE, 3'd6, 3'd6, 3'd6);
        step();
        n = 0;
        while (rdy[0] == 1'b0 && n < 20) begin
            if (n == 3) begin
                idle(3'd2, 3'd3);
                #1;
                chk("clr3_r2", out1[0], 8'h00);
                chk("clr3_r3", out2[0], 8'h44);
            end else if (n == 4) begin
                drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h99, 3'd5, 3'd5, 3'd4);
            end else begin
                idle(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end
            step();
            n++;
        end
        chk("clear_ready_low_cycles", 8'(n), 8'd8);
        for (int k = 0; k < 4; k++) begin
            idle(3'(2*k), 3'(2*k+1));
            #1;
            chk("after_clear_out1", out1[0], 8'h00);
            chk("after_clear_out2", out2[0], 8'h00);
            step();
        end

        // Reset in the middle of a clear.
        for (int k = 0; k < c_DEPTH; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h21 + k), 3'(k), 3'(k), 3'(k));
            step();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd7, 3'd6);
        step();
        for (int k = 0; k < 4; k++) begin
            idle(3'd7, 3'd6);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd7, 3'd6);
        step();
        idle(3'd7, 3'd6);
        #1;
        chk("rstmid_ready", {7'd0, rdy[0]}, 8'd1);
        chk("rstmid_r7", out1[0], 8'h00);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h42, 3'd1, 3'd5, 3'd4);
        step();
        idle(3'd1, 3'd1);
        #1;
        chk("rstmid_write_r1", out1[0], 8'h42);
        step();

        // Randomised traffic against the model.
        for (int k = 0; k < 500; k++) begin
            drive(($urandom % 60) != 0, 1'($urandom), ($urandom % 4) == 0,
                  ($urandom % 30) == 0, 8'($urandom), 3'($urandom),
                  3'($urandom), 3'($urandom));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
